alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 116 +++++++++++
 tb/tb_alu_seq.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith ops plus a bit-serial shift-add
// multiplier that holds the result register until the product is ready.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [2:0]         func,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] ALUOUT,
  output logic               zero,
  output logic               busy,
  output logic               done
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_LOG = 3'b010;
  localparam logic [2:0] F_ANY = 3'b011;
  localparam logic [2:0] F_CAT = 3'b100;
  localparam logic [2:0] F_MUL = 3'b101;
  localparam logic [2:0] F_ACC = 3'b110;
  localparam logic [2:0] F_SHL = 3'b111;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic             armed;

  logic [W2-1:0]    res;
  logic [WIDTH-1:0] diff;
  logic [W2-1:0]    prod_nxt;
  logic             accept;

  // The first edge after reset release only arms the block, so a start that
  // races the deassertion is never taken.
  assign accept   = start && (state == IDLE) && armed;
  assign diff     = A - B;
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);

  always_comb begin
    res = '0;
    unique case (func)
      F_ADD: res = {{WIDTH{1'b0}}, A} + {{WIDTH{1'b0}}, B};
      F_SUB: res = {{WIDTH{diff[WIDTH-1]}}, diff};
      F_LOG: res = {A | B, A ^ B};
      F_ANY: res = {{(W2-1){1'b0}}, (|A) | (|B)};
      F_CAT: res = {A, B};
      F_ACC: res = ALUOUT + {{WIDTH{1'b0}}, B};
      F_SHL: begin
        if ({{(32-WIDTH){1'b0}}, A} >= 32'(W2)) res = '0;
        else                                    res = ALUOUT << A;
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      armed  <= 1'b0;
      ALUOUT <= '0;
      zero   <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (func == F_MUL) begin
              state  <= MUL;
              busy   <= 1'b1;
              cnt    <= '0;
              prod   <= '0;
              mcand  <= {{WIDTH{1'b0}}, A};
              mplier <= B;
            end else begin
              ALUOUT <= res;
              zero   <= (res == '0);
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            ALUOUT <= prod_nxt;
            zero   <= (prod_nxt == '0);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=4): inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_alu_seq;
  logic       clock;
  logic       resetn;
  logic       start;
  logic [2:0] func;
  logic [3:0] A;
  logic [3:0] B;
  logic [7:0] ALUOUT;
  logic       zero;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(4)) dut (
    .clock (clock),
    .resetn(resetn),
    .start (start),
    .func  (func),
    .A     (A),
    .B     (B),
    .ALUOUT(ALUOUT),
    .zero  (zero),
    .busy  (busy),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request, let one edge take it, then drop start.
  task automatic op(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    start = 1'b1;
    func  = f;
    A     = a;
    B     = b;
    tick();
    start = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    func   = 3'b000;
    A      = 4'h0;
    B      = 4'h0;
    tick();
    tick();
    chk("rst_aluout", 32'(ALUOUT), 32'h00);
    chk("rst_zero",   32'(zero),   32'h1);
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_done",   32'(done),   32'h0);

    // Release reset less than a cycle before an edge carrying a start.
    resetn = 1'b1;
    op(3'b000, 4'h1, 4'h1);
    chk("race_done",   32'(done),   32'h0);
    chk("race_aluout", 32'(ALUOUT), 32'h00);
    tick();

    op(3'b000, 4'hF, 4'h1);
    chk("add_out",  32'(ALUOUT), 32'h10);
    chk("add_zero", 32'(zero),   32'h0);
    chk("add_done", 32'(done),   32'h1);
    chk("add_busy", 32'(busy),   32'h0);
    tick();
    chk("add_done_drop", 32'(done),   32'h0);
    chk("add_hold",      32'(ALUOUT), 32'h10);

    op(3'b001, 4'h3, 4'h5);
    chk("sub_neg", 32'(ALUOUT), 32'hFE);
    chk("sub_neg_done", 32'(done), 32'h1);
    op(3'b001, 4'h5, 4'h5);
    chk("sub_eq",      32'(ALUOUT), 32'h00);
    chk("sub_eq_zero", 32'(zero),   32'h1);

    op(3'b010, 4'hC, 4'hA);
    chk("orxor", 32'(ALUOUT), 32'hE6);
    op(3'b011, 4'h0, 4'h0);
    chk("any_none", 32'(ALUOUT), 32'h00);
    chk("any_none_zero", 32'(zero), 32'h1);
    op(3'b011, 4'h0, 4'h4);
    chk("any_set", 32'(ALUOUT), 32'h01);
    op(3'b100, 4'hA, 4'h5);
    chk("cat", 32'(ALUOUT), 32'hA5);

    // Multiply: operands change and start is re-asserted while busy.
    op(3'b101, 4'hF, 4'hF);
    chk("mul_busy0", 32'(busy),   32'h1);
    chk("mul_done0", 32'(done),   32'h0);
    chk("mul_hold0", 32'(ALUOUT), 32'hA5);
    for (int i = 1; i < 4; i++) begin
      start = 1'b1;
      func  = 3'b000;
      A     = 4'h1;
      B     = 4'h1;
      tick();
      chk("mul_busy", 32'(busy),   32'h1);
      chk("mul_done", 32'(done),   32'h0);
      chk("mul_hold", 32'(ALUOUT), 32'hA5);
    end
    start = 1'b0;
    tick();
    chk("mul_out",  32'(ALUOUT), 32'hE1);
    chk("mul_fin",  32'(done),   32'h1);
    chk("mul_idle", 32'(busy),   32'h0);
    chk("mul_zero", 32'(zero),   32'h0);
    tick();
    chk("mul_done_drop", 32'(done),   32'h0);
    chk("mul_keep",      32'(ALUOUT), 32'hE1);

    op(3'b100, 4'hF, 4'hF);
    chk("acc_pre", 32'(ALUOUT), 32'hFF);
    op(3'b110, 4'h0, 4'h2);
    chk("acc_wrap", 32'(ALUOUT), 32'h01);
    op(3'b111, 4'h7, 4'h0);
    chk("shl7", 32'(ALUOUT), 32'h80);
    op(3'b111, 4'h8, 4'h0);
    chk("shl8",      32'(ALUOUT), 32'h00);
    chk("shl8_zero", 32'(zero),   32'h1);

    // Reset two cycles into a multiply.
    op(3'b101, 4'h3, 4'h3);
    tick();
    chk("rmul_busy", 32'(busy), 32'h1);
    resetn = 1'b0;
    #1;
    chk("rmul_out",  32'(ALUOUT), 32'h00);
    chk("rmul_busy0", 32'(busy),  32'h0);
    chk("rmul_zero", 32'(zero),   32'h1);
    tick();
    tick();
    chk("rmul_nodone", 32'(done), 32'h0);
    resetn = 1'b1;
    tick();
    chk("rmul_nodone2", 32'(done), 32'h0);
    op(3'b000, 4'h2, 4'h3);
    chk("post_add",      32'(ALUOUT), 32'h05);
    chk("post_add_done", 32'(done),   32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
